rob_multi_commit: RTL and testbench
===================================

Name: rob_multi_commit

Overview:
- Parametrised in-order retirement buffer for the out-of-order core; successor to the single-commit ROB.
- Allocates one entry per cycle from the decoder and accepts results from CDB_PORTS write-back channels.
- Retires up to COMMIT_W consecutive ready entries per cycle to the regfile.
- Drives the data cache for store commit and raises flush on a committed branch mispredict.

Parameters:
- DEPTH, 8, number of entries. Tags run 1..DEPTH; tag 0 means "no tag".
- TAG_W, 4, tag width. Must satisfy 2^TAG_W > DEPTH.
- CDB_PORTS, 3, number of write-back channels.
- COMMIT_W, 2, maximum register/branch retirements per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  decoder requests an entry
- alloc_type  in  2  0=REG, 1=ST, 2=BR
- alloc_dest  in  5  destination register (REG only)
- alloc_ready  out  1  an entry is free
- alloc_tag  out  TAG_W  tag given to the current request
- wb_valid  in  CDB_PORTS  write-back strobe per channel
- wb_tag  in  CDB_PORTS*TAG_W  entry tag per channel
- wb_val  in  CDB_PORTS*32  result, or store data
- wb_addr  in  CDB_PORTS*32  store address, or correct branch target
- wb_mispred  in  CDB_PORTS  branch resolved mispredicted
- cm_valid  out  COMMIT_W  retire strobe per slot
- cm_rd  out  COMMIT_W*5  register written
- cm_val  out  COMMIT_W*32  value written
- cm_tag  out  COMMIT_W*TAG_W  tag retired
- mem_write  out  1  store request
- mem_address  out  32  word-aligned store address
- mem_wdata  out  32  store data
- mem_resp  in  1  cache completes the store
- flush  out  1  mispredict flush
- flush_pc  out  32  redirect target
- count  out  TAG_W+1  number of occupied entries

Behaviour:
- Storage and pointers:
  - Circular buffer with head (oldest) and tail pointers, both cycling 1..DEPTH and wrapping DEPTH->1.
  - Each entry holds type, dest, val, addr, ready, mispred.
- Reset: head=tail=1, count=0, all entries cleared, store FSM in IDLE. All outputs 0 except alloc_ready=1 and alloc_tag=1.
- Allocation:
  - alloc_ready = (count < DEPTH), using registered count only.
  - alloc_tag = tail when alloc_ready=1, else 0.
  - When alloc_valid && alloc_ready: the entry is written with ready=0 and tail advances at the clock edge.
  - A slot freed by commit in the same cycle is not reusable until the next cycle.
- Write-back:
  - For each channel with wb_valid set, the tagged entry gets val, addr and mispred, and ready=1 at the clock edge.
  - Writes to tag 0 or to a free entry are ignored.
  - Channels never target the same tag in the same cycle.
- Commit window:
  - Candidate slot k is entry head+k (with wrap), k < COMMIT_W.
  - A slot commits only if it is occupied, its registered ready=1, and every older slot in the window commits.
- Commit of REG entries: cm_valid[k]=1 with cm_rd, cm_val, cm_tag. Combinational, zero latency.
- Commit of BR entries:
  - Retires silently when mispred=0.
  - When mispred=1: the branch retires, flush=1 and flush_pc=addr in that cycle, and younger slots are suppressed.
  - Next edge: all entries cleared, head=tail=1, count=0. Any alloc in the flush cycle is dropped.
- Commit of ST entries: a store is eligible only in slot 0; any younger slot stops at a store.
- Store FSM:
  - IDLE -> WRITE when the head entry is a ready ST. mem_write=1 with mem_address={addr[31:2],2'b00} and mem_wdata=val.
  - WRITE: mem_write is held with stable address and data until mem_resp.
  - On mem_resp: the store retires in that cycle (head+1, count-1) and the FSM returns to IDLE.
  - The cycle the FSM enters WRITE never also retires the store.
- Count update: count_next = count + alloc_fire - retired. It never exceeds DEPTH or goes below 0.
- Empty: count=0 gives all cm_valid=0 and mem_write=0.
- Reset while in WRITE: mem_write=0 from the next cycle and the store is discarded.

Optional Feature:
- Macro ROB_BYPASS_EN.
- When defined, adds 2 operand read ports:
  - rd_tag  in  2*TAG_W
  - rd_ready  out  2
  - rd_val  out  2*32
- Each port returns the entry's ready bit and value.
- Same-cycle forwarding: if any wb channel targets rd_tag this cycle, rd_ready=1 and rd_val=wb_val.
- rd_tag=0 returns rd_ready=0, rd_val=0.
- When undefined, the ports are absent and decode waits one cycle for the registered ready bit.

Test Plan:
- Allocate 8 REG entries (dest x1..x8) -> alloc_tag 1..8, then alloc_ready=0 and count=8. A 9th alloc_valid is ignored.
- Write back tags 2 then 1 (vals 0x22, 0x11) -> the next cycle commits both in one cycle: cm_rd={x1,x2}, cm_val={0x11,0x22}.
- ST at head with wb_addr=0x1006, wb_val=0xAB -> mem_write=1, mem_address=0x1004. The store holds 3 cycles until mem_resp, then retires and count decrements.
- BR at tag 3 with wb_mispred=1, wb_addr=0x400, tags 4-5 ready -> flush=1 and flush_pc=0x400 on the branch commit, tags 4-5 not committed, count=0 the next cycle.
- Fill to DEPTH, then drain and refill -> tail wraps 8->1 with tags in order. Simultaneous alloc+commit keeps count constant.
- rst asserted while in WRITE -> mem_write=0 and count=0 the next cycle, and alloc_tag=1.

Source files
------------

// File: rtl/rob_multi_commit.sv
// In-order retirement buffer: one alloc per cycle, CDB_PORTS write-backs, up to COMMIT_W
// retirements, store handshake with the D-cache and mispredict flush. Optional bypass: ROB_BYPASS_EN.
module rob_multi_commit #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 4,
  parameter int CDB_PORTS = 3,
  parameter int COMMIT_W  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alloc_valid,
  input  logic [1:0]                           alloc_type,
  input  logic [4:0]                           alloc_dest,
  output logic                                 alloc_ready,
  output logic [TAG_W-1:0]                     alloc_tag,
  input  logic [CDB_PORTS-1:0]                 wb_valid,
  input  logic [CDB_PORTS-1:0][TAG_W-1:0]      wb_tag,
  input  logic [CDB_PORTS-1:0][31:0]           wb_val,
  input  logic [CDB_PORTS-1:0][31:0]           wb_addr,
  input  logic [CDB_PORTS-1:0]                 wb_mispred,
  output logic [COMMIT_W-1:0]                  cm_valid,
  output logic [COMMIT_W-1:0][4:0]             cm_rd,
  output logic [COMMIT_W-1:0][31:0]            cm_val,
  output logic [COMMIT_W-1:0][TAG_W-1:0]       cm_tag,
  output logic                                 mem_write,
  output logic [31:0]                          mem_address,
  output logic [31:0]                          mem_wdata,
  input  logic                                 mem_resp,
  output logic                                 flush,
  output logic [31:0]                          flush_pc,
  output logic [TAG_W:0]                       count
`ifdef ROB_BYPASS_EN
  ,
  input  logic [1:0][TAG_W-1:0]                rd_tag,
  output logic [1:0]                           rd_ready,
  output logic [1:0][31:0]                     rd_val
`endif
);
  localparam logic [1:0]     T_REG   = 2'd0;
  localparam logic [1:0]     T_ST    = 2'd1;
  localparam logic [1:0]     T_BR    = 2'd2;
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        mispred;
    logic [1:0]  typ;
    logic [4:0]  dest;
    logic [31:0] val;
    logic [31:0] addr;
  } ent_t;

  typedef enum logic {S_IDLE, S_WRITE} st_state_t;

  // Tags are 1-based pointers that wrap DEPTH -> 1.
  function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] p, input logic [TAG_W:0] k);
    logic [TAG_W+1:0] s;
    s = {2'b00, p} + {1'b0, k};
    if (s > (TAG_W+2)'(DEPTH)) s = s - (TAG_W+2)'(DEPTH);
    return s[TAG_W-1:0];
  endfunction

  ent_t                             ent [1:DEPTH];
  logic [TAG_W-1:0]                 head, tail;
  st_state_t                        st_state;
  logic [COMMIT_W-1:0][TAG_W-1:0]   slot_tag;
  logic [COMMIT_W-1:0]              occ, retire;
  logic [TAG_W:0]                   n_ret;
  logic                             go, alloc_fire;

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
    assign slot_tag[k] = wrap_add(head, (TAG_W+1)'(k));
    assign occ[k]      = count > (TAG_W+1)'(k);
  end

  assign alloc_ready = count < DEPTH_C;
  assign alloc_tag   = alloc_ready ? tail : '0;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  // Commit window: a prefix of ready slots; stores only retire from slot 0 via the FSM.
  always_comb begin
    cm_valid = '0;
    cm_rd    = '0;
    cm_val   = '0;
    cm_tag   = '0;
    retire   = '0;
    flush    = 1'b0;
    flush_pc = '0;
    n_ret    = '0;
    go       = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (go && occ[k] && ent[slot_tag[k]].ready) begin
        case (ent[slot_tag[k]].typ)
          T_REG: begin
            retire[k]   = 1'b1;
            cm_valid[k] = 1'b1;
            cm_rd[k]    = ent[slot_tag[k]].dest;
            cm_val[k]   = ent[slot_tag[k]].val;
            cm_tag[k]   = slot_tag[k];
          end
          T_ST: begin
            go        = 1'b0;
            retire[k] = (k == 0) && (st_state == S_WRITE) && mem_resp;
          end
          T_BR: begin
            retire[k] = 1'b1;
            if (ent[slot_tag[k]].mispred) begin
              flush    = 1'b1;
              flush_pc = ent[slot_tag[k]].addr;
              go       = 1'b0;
            end
          end
          default: retire[k] = 1'b1;
        endcase
      end else begin
        go = 1'b0;
      end
      if (retire[k]) n_ret = n_ret + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= TAG_W'(1);
      tail  <= TAG_W'(1);
      count <= '0;
      for (int i = 1; i <= DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int c = 0; c < CDB_PORTS; c++) begin
        if (wb_valid[c] && wb_tag[c] != '0 && {1'b0, wb_tag[c]} <= DEPTH_C && ent[wb_tag[c]].busy) begin
          ent[wb_tag[c]].val     <= wb_val[c];
          ent[wb_tag[c]].addr    <= wb_addr[c];
          ent[wb_tag[c]].mispred <= wb_mispred[c];
          ent[wb_tag[c]].ready   <= 1'b1;
        end
      end
      for (int k = 0; k < COMMIT_W; k++)
        if (retire[k]) ent[slot_tag[k]] <= '0;
      if (alloc_fire) begin
        ent[tail] <= '{busy: 1'b1, ready: 1'b0, mispred: 1'b0, typ: alloc_type,
                       dest: alloc_dest, val: 32'h0, addr: 32'h0};
        tail <= wrap_add(tail, (TAG_W+1)'(1));
      end
      head  <= wrap_add(head, n_ret);
      count <= count + (TAG_W+1)'(alloc_fire) - n_ret;
    end
  end

  // Store port: launch from a ready head store, hold until the cache answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_state    <= S_IDLE;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (st_state)
        S_IDLE: if (occ[0] && ent[head].ready && ent[head].typ == T_ST) begin
          st_state    <= S_WRITE;
          mem_write   <= 1'b1;
          mem_address <= {ent[head].addr[31:2], 2'b00};
          mem_wdata   <= ent[head].val;
        end
        S_WRITE: if (mem_resp) begin
          st_state  <= S_IDLE;
          mem_write <= 1'b0;
        end
        default: st_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROB_BYPASS_EN
  always_comb begin
    rd_ready = '0;
    rd_val   = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_tag[p] != '0 && {1'b0, rd_tag[p]} <= DEPTH_C) begin
        rd_ready[p] = ent[rd_tag[p]].ready;
        rd_val[p]   = ent[rd_tag[p]].val;
        for (int c = 0; c < CDB_PORTS; c++) begin
          if (wb_valid[c] && wb_tag[c] == rd_tag[p]) begin
            rd_ready[p] = 1'b1;
            rd_val[p]   = wb_val[c];
          end
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: queue-based reference model checked every cycle,
// plus literal spot checks at the interesting points of each scenario.
module tb_rob_multi_commit;
  localparam int DEPTH = 8, TAG_W = 4, CDB = 3, CW = 2;

  logic                      clk = 1'b0, rst;
  logic                      alloc_valid;
  logic [1:0]                alloc_type;
  logic [4:0]                alloc_dest;
  logic                      alloc_ready;
  logic [TAG_W-1:0]          alloc_tag;
  logic [CDB-1:0]            wb_valid;
  logic [CDB-1:0][TAG_W-1:0] wb_tag;
  logic [CDB-1:0][31:0]      wb_val, wb_addr;
  logic [CDB-1:0]            wb_mispred;
  logic [CW-1:0]             cm_valid;
  logic [CW-1:0][4:0]        cm_rd;
  logic [CW-1:0][31:0]       cm_val;
  logic [CW-1:0][TAG_W-1:0]  cm_tag;
  logic                      mem_write, mem_resp, flush;
  logic [31:0]               mem_address, mem_wdata, flush_pc;
  logic [TAG_W:0]            count;

  always #5 clk = ~clk;

  rob_multi_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_PORTS(CDB), .COMMIT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_addr(wb_addr), .wb_mispred(wb_mispred),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_tag(cm_tag),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of live entries.
  typedef struct {
    int       tag;
    int       typ;
    int       dest;
    bit [31:0] val;
    bit [31:0] addr;
    bit       rdy;
    bit       mis;
  } m_ent_t;

  m_ent_t    q[$];
  int        m_tail = 1;
  bit        m_wr = 0;
  bit [31:0] m_addr, m_data;
  bit        started = 0;

  bit        e_ready, e_flush;
  int        e_tag, nret;
  bit [1:0]  e_cv;
  bit [31:0] e_fpc;
  int        e_rd[CW], e_ctag[CW];
  bit [31:0] e_val[CW];

  always @(negedge clk) begin
    e_ready = q.size() < DEPTH;
    e_tag   = e_ready ? m_tail : 0;
    e_cv = '0; nret = 0; e_flush = 0; e_fpc = '0;
    for (int k = 0; k < CW && k < q.size(); k++) begin
      if (!q[k].rdy) break;
      if (q[k].typ == 1) begin
        if (k == 0 && m_wr && mem_resp) nret++;
        break;
      end
      nret++;
      if (q[k].typ == 2) begin
        if (q[k].mis) begin e_flush = 1; e_fpc = q[k].addr; break; end
      end else begin
        e_cv[k] = 1'b1; e_rd[k] = q[k].dest; e_val[k] = q[k].val; e_ctag[k] = q[k].tag;
      end
    end

    if (started) begin
      check("alloc_ready", 32'(alloc_ready), 32'(e_ready));
      check("alloc_tag", 32'(alloc_tag), 32'(e_tag));
      check("count", 32'(count), 32'(q.size()));
      check("flush", 32'(flush), 32'(e_flush));
      if (e_flush) check("flush_pc", flush_pc, e_fpc);
      check("mem_write", 32'(mem_write), 32'(m_wr));
      if (m_wr) begin
        check("mem_address", mem_address, m_addr);
        check("mem_wdata", mem_wdata, m_data);
      end
      check("cm_valid", 32'(cm_valid), 32'(e_cv));
      for (int k = 0; k < CW; k++) begin
        if (e_cv[k]) begin
          check($sformatf("cm_rd[%0d]", k), 32'(cm_rd[k]), 32'(e_rd[k]));
          check($sformatf("cm_val[%0d]", k), cm_val[k], e_val[k]);
          check($sformatf("cm_tag[%0d]", k), 32'(cm_tag[k]), 32'(e_ctag[k]));
        end
      end
    end

    if (rst) begin
      q.delete(); m_tail = 1; m_wr = 0; started = 1;
    end else begin
      if (!m_wr) begin
        if (q.size() > 0 && q[0].rdy && q[0].typ == 1) begin
          m_wr = 1; m_addr = q[0].addr & ~32'h3; m_data = q[0].val;
        end
      end else if (mem_resp) m_wr = 0;
      if (e_flush) begin
        q.delete(); m_tail = 1;
      end else begin
        for (int c = 0; c < CDB; c++)
          if (wb_valid[c])
            foreach (q[i])
              if (q[i].tag == int'(wb_tag[c])) begin
                q[i].val = wb_val[c]; q[i].addr = wb_addr[c]; q[i].mis = wb_mispred[c]; q[i].rdy = 1;
              end
        repeat (nret) void'(q.pop_front());
        if (alloc_valid && e_ready) begin
          q.push_back('{tag: m_tail, typ: int'(alloc_type), dest: int'(alloc_dest),
                        val: 32'h0, addr: 32'h0, rdy: 1'b0, mis: 1'b0});
          m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    alloc_valid = 0; wb_valid = '0; wb_mispred = '0; mem_resp = 0;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] d);
    alloc_valid = 1; alloc_type = t; alloc_dest = d;
  endtask

  task automatic wb(input int c, input int tag, input logic [31:0] v, input logic [31:0] a, input bit m);
    wb_valid[c] = 1; wb_tag[c] = TAG_W'(tag); wb_val[c] = v; wb_addr[c] = a; wb_mispred[c] = m;
  endtask

  initial begin
    rst = 1; alloc_valid = 0; alloc_type = 0; alloc_dest = 0;
    wb_valid = '0; wb_tag = '0; wb_val = '0; wb_addr = '0; wb_mispred = '0; mem_resp = 0;
    tick(); tick();
    rst = 0;

    // Reset state; stray write-backs to tag 0 and a free tag must be harmless.
    wb(0, 0, 32'hDEAD, 32'h0, 0); wb(1, 5, 32'hBEEF, 32'h0, 0);
    @(negedge clk);
    check("rst count", 32'(count), 0);
    check("rst alloc_ready", 32'(alloc_ready), 1);
    check("rst alloc_tag", 32'(alloc_tag), 1);
    check("rst mem_write", 32'(mem_write), 0);
    check("rst cm_valid", 32'(cm_valid), 0);
    check("rst flush", 32'(flush), 0);
    tick();

    // Fill: tags 1..8, then full.
    for (int i = 1; i <= 8; i++) begin
      alloc(2'd0, 5'(i));
      @(negedge clk);
      check($sformatf("fill alloc_tag %0d", i), 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc(2'd0, 5'd9);
    @(negedge clk);
    check("full count", 32'(count), 8);
    check("full alloc_ready", 32'(alloc_ready), 0);
    check("full alloc_tag", 32'(alloc_tag), 0);
    tick();
    @(negedge clk);
    check("9th alloc ignored", 32'(count), 8);
    tick();

    // Out-of-order write-back, dual commit.
    wb(0, 2, 32'h22, 32'h0, 0);
    tick();
    wb(0, 1, 32'h11, 32'h0, 0);
    @(negedge clk);
    check("head not ready", 32'(cm_valid), 0);
    tick();
    @(negedge clk);
    check("dual cm_valid", 32'(cm_valid), 32'h3);
    check("dual cm_rd0", 32'(cm_rd[0]), 1);
    check("dual cm_rd1", 32'(cm_rd[1]), 2);
    check("dual cm_val0", cm_val[0], 32'h11);
    check("dual cm_val1", cm_val[1], 32'h22);
    tick();

    // Drain while refilling; tail wraps to 1.
    wb(0, 3, 32'h33, 0, 0); wb(1, 4, 32'h44, 0, 0); wb(2, 5, 32'h55, 0, 0);
    alloc(2'd0, 5'd9);
    @(negedge clk);
    check("wrap alloc_tag", 32'(alloc_tag), 1);
    tick();
    alloc(2'd0, 5'd10); wb(0, 6, 32'h66, 0, 0); wb(1, 7, 32'h77, 0, 0); wb(2, 8, 32'h88, 0, 0);
    tick();
    alloc(2'd2, 5'd0);
    tick();
    wb(0, 1, 32'h91, 0, 0);
    tick();
    alloc(2'd0, 5'd12); wb(0, 2, 32'h92, 0, 0); wb(1, 3, 32'h0, 32'h123, 0);
    @(negedge clk);
    check("pre alloc+commit count", 32'(count), 3);
    check("single commit", 32'(cm_valid), 32'h1);
    tick();
    @(negedge clk);
    check("alloc+commit count", 32'(count), 3);
    check("reg+silent br", 32'(cm_valid), 32'h1);
    tick();
    wb(0, 4, 32'h94, 0, 0);
    tick();
    tick();

    // Store at head: hold until mem_resp.
    alloc(2'd1, 5'd0);
    @(negedge clk);
    check("st alloc_tag", 32'(alloc_tag), 5);
    tick();
    wb(0, 5, 32'hAB, 32'h1006, 0); alloc(2'd0, 5'd13);
    tick();
    @(negedge clk);
    check("st not yet", 32'(mem_write), 0);
    tick();
    @(negedge clk);
    check("st mem_write", 32'(mem_write), 1);
    check("st mem_address", mem_address, 32'h1004);
    check("st mem_wdata", mem_wdata, 32'hAB);
    tick();
    wb(0, 6, 32'h66, 0, 0);
    tick();
    tick();
    mem_resp = 1;
    @(negedge clk);
    check("st resp count", 32'(count), 2);
    check("st resp mem_write", 32'(mem_write), 1);
    tick();
    @(negedge clk);
    check("st done mem_write", 32'(mem_write), 0);
    check("st done count", 32'(count), 1);
    check("after st cm_rd0", 32'(cm_rd[0]), 13);
    tick();

    // Mispredicted branch at tag 3.
    rst = 1; tick(); rst = 0;
    alloc(2'd0, 5'd1); tick();
    alloc(2'd0, 5'd2); tick();
    alloc(2'd2, 5'd0); tick();
    alloc(2'd0, 5'd4); tick();
    alloc(2'd0, 5'd5); tick();
    wb(0, 3, 32'h0, 32'h400, 1); wb(1, 4, 32'h44, 0, 0); wb(2, 5, 32'h55, 0, 0);
    tick();
    wb(0, 1, 32'h11, 0, 0); wb(1, 2, 32'h22, 0, 0);
    tick();
    @(negedge clk);
    check("pre-br cm_valid", 32'(cm_valid), 32'h3);
    tick();
    alloc(2'd0, 5'd7);
    @(negedge clk);
    check("br flush", 32'(flush), 1);
    check("br flush_pc", flush_pc, 32'h400);
    check("br younger suppressed", 32'(cm_valid), 0);
    tick();
    @(negedge clk);
    check("post-flush count", 32'(count), 0);
    check("post-flush flush", 32'(flush), 0);
    check("post-flush alloc_tag", 32'(alloc_tag), 1);
    tick();

    // Reset during store WRITE.
    alloc(2'd1, 5'd0); tick();
    wb(0, 1, 32'h5A, 32'h2008, 0); tick();
    tick();
    rst = 1;
    @(negedge clk);
    check("rstwr mem_write", 32'(mem_write), 1);
    check("rstwr mem_address", mem_address, 32'h2008);
    tick();
    rst = 0;
    @(negedge clk);
    check("rstwr after mem_write", 32'(mem_write), 0);
    check("rstwr after count", 32'(count), 0);
    check("rstwr after alloc_tag", 32'(alloc_tag), 1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
